mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester path and of y.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per requester; used only when the timeout feature is compiled in.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  2  request lines; bit k is requester k.
REQ-006 i0  input  WIDTH  requester 0 data.
REQ-007 i1  input  WIDTH  requester 1 data.
REQ-008 gnt  output  2  grant, one-hot or zero, registered.
REQ-009 s  output  1  mux select driven to the shared 2:1 datapath, registered.
REQ-010 y  output  WIDTH  registered mux output.
REQ-011 valid  output  1  y holds data from a granted requester.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, G0 and G1, plus a 1-bit last-served register.
REQ-013 In IDLE, when only req[0]=1 the FSM SHALL enter G0, and when only req[1]=1 it SHALL enter G1.
REQ-014 In IDLE, when req=11 the FSM SHALL grant the requester not equal to last.
REQ-015 In IDLE, when req=00 the FSM SHALL stay in IDLE.
REQ-016 Grant latency SHALL be one cycle: gnt asserts on the edge after req is first sampled high.
REQ-017 In Gk the FSM SHALL remain in Gk while req[k]=1, subject to REQ-029.
REQ-018 When req[k] falls in Gk and the other request is high, the FSM SHALL go directly to the other grant state with no IDLE bubble.
REQ-019 When req[k] falls in Gk and the other request is low, the FSM SHALL go to IDLE.
REQ-020 last SHALL be updated to k on entry to Gk.
REQ-021 gnt SHALL be 01 in G0, 10 in G1 and 00 in IDLE; it SHALL never be 11.
REQ-022 s SHALL be 1 in G1 and 0 in G0 and IDLE.
REQ-023 On each edge while in G0 or G1, y SHALL load the data selected by s (i0 when s=0, i1 when s=1) and valid SHALL load 1.
REQ-024 y and valid therefore SHALL lag gnt by one cycle.
REQ-025 On each edge while in IDLE, valid SHALL load 0 and y SHALL hold its value.
REQ-026 A request dropped and re-raised in consecutive cycles SHALL be treated as a new request and arbitrated per REQ-013 and REQ-014.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL load state=IDLE, gnt=00, s=0, y=0, valid=0, last=1 and hold counter=0, regardless of req.
REQ-028 Reset asserted mid-grant SHALL abort the grant, and on the first edge with rst_n=1 arbitration SHALL restart from IDLE; because last=1, req0 wins the first tie.

Configuration
REQ-029 With macro ARB_TIMEOUT_EN defined:
- A hold counter SHALL count consecutive cycles in Gk.
- When the counter equals MAX_HOLD-1 and the other request is high, the FSM SHALL switch to the other grant state on the next edge even if req[k] is still 1.
- The counter SHALL clear on every grant change and in IDLE.
- When the other request is low, the counter SHALL saturate and the grant SHALL continue.
REQ-030 With ARB_TIMEOUT_EN undefined, the FSM SHALL have no hold counter and no preemption; the grant is held until req[k] falls.

Verification
REQ-031 Reset then req=01 with i0=8'hA5 -> gnt=01 and s=0 after 1 edge; y=A5 and valid=1 after 2 edges.
REQ-032 req=11 from IDLE after reset -> G0 first; drop req[0] -> gnt=10 and s=1 on the next edge with no gnt=00 cycle; y follows i1=8'h3C one edge later.
REQ-033 Alternating tie: req=11 each time from IDLE, three times with a one-cycle req=00 gap between them -> grants G0, G1, G0.
REQ-034 rst_n=0 for one edge while in G1 with valid=1 -> next outputs gnt=00, s=0, y=00, valid=0; after rst_n=1 with req=11 -> G0.
REQ-035 ARB_TIMEOUT_EN with MAX_HOLD=4, req held at 11 -> gnt toggles every 4 cycles (01 x4, 10 x4, ...); without the macro -> gnt stays 01 indefinitely.
REQ-036 Random req, i0 and i1 for 200 cycles from a fixed seed -> gnt is never 11, s equals gnt[1], and valid with y matches a reference model every cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-requester round-robin arbiter driving a registered 2:1 mux.
// Ports: clk, rst_n (sync, active-low), req[1:0], i0/i1[WIDTH-1:0] data in;
// gnt[1:0] one-hot or zero grant, s mux select, y muxed data, valid (y holds granted data).
// Optional macro ARB_TIMEOUT_EN adds a hold counter that preempts a grant after MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [1:0]       gnt,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             valid
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_nx;
  logic last;
  logic pre0, pre1;
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] hold;
  logic at_max;
  assign at_max = hold == CW'(MAX_HOLD - 1);
  // A grant is preempted only when it has used its full hold and the other side is waiting.
  assign pre0 = at_max && req[1];
  assign pre1 = at_max && req[0];
  always_ff @(posedge clk) begin
    if (!rst_n) hold <= '0;
    else hold <= (state_nx != state || state_nx == IDLE) ? '0 : at_max ? hold : hold + 1'b1;
  end
`else
  assign pre0 = 1'b0;
  assign pre1 = 1'b0;
`endif
  // On a tie from IDLE the requester that was not served last wins.
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE:    state_nx = (req[0] && (!req[1] || last)) ? G0 : req[1] ? G1 : IDLE;
      G0:      state_nx = (req[0] && !pre0) ? G0 : req[1] ? G1 : IDLE;
      G1:      state_nx = (req[1] && !pre1) ? G1 : req[0] ? G0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 2'b00;
      s     <= 1'b0;
      y     <= '0;
      valid <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      gnt   <= {state_nx == G1, state_nx == G0};
      s     <= state_nx == G1;
      if (state_nx != IDLE) last <= state_nx == G1;
      valid <= state != IDLE;
      if (state != IDLE) y <= s ? i1 : i0;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of mux_rr_arbiter against a behavioural model.
module tb_mux_rr_arbiter;
  localparam int W = 8;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [W-1:0] i0, i1;
  logic [1:0] gnt;
  logic s;
  logic [W-1:0] y;
  logic valid;
  int n_chk = 0;
  int n_fail = 0;
  int m_owner;
  int m_last;
  int m_hold;
  logic [W-1:0] m_y;
  logic m_valid;
  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .i0(i0), .i1(i1),
    .gnt(gnt), .s(s), .y(y), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: owner is -1 when nobody holds the grant, else the requester index.
  task automatic model_edge();
    int nxt, other;
    bit expired;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_hold = 0; m_y = '0; m_valid = 1'b0;
      return;
    end
    m_valid = m_owner >= 0;
    if (m_owner >= 0) m_y = (m_owner == 1) ? i1 : i0;
    if (m_owner < 0) begin
      if (req == 2'b00) nxt = -1;
      else if (req == 2'b11) nxt = 1 - m_last;
      else nxt = req[1] ? 1 : 0;
    end else begin
      other = 1 - m_owner;
      expired = TIMEOUT && m_hold == MH - 1 && req[other];
      if (req[m_owner] && !expired) nxt = m_owner;
      else if (req[other]) nxt = other;
      else nxt = -1;
    end
    if (nxt != m_owner || nxt < 0) m_hold = 0;
    else if (m_hold < MH - 1) m_hold++;
    if (nxt >= 0) m_last = nxt;
    m_owner = nxt;
  endtask
  task automatic step(input logic [1:0] r, input logic rn);
    logic [1:0] eg;
    req = r;
    rst_n = rn;
    model_edge();
    @(posedge clk);
    #1;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    check("model_gnt", gnt, eg);
    check("model_s", s, m_owner == 1);
    check("model_valid", valid, m_valid);
    check("model_y", y, m_y);
    check("gnt_not_11", gnt != 2'b11, 1);
    check("s_eq_gnt1", s, gnt[1]);
  endtask
  initial begin
    rst_n = 1'b0; req = 2'b00; i0 = '0; i1 = '0;
    m_owner = -1; m_last = 1; m_hold = 0; m_y = '0; m_valid = 1'b0;
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_y", y, 8'h00);
    check("rst_valid", valid, 1'b0);
    i0 = 8'hA5;
    step(2'b01, 1'b1);
    check("r31_gnt", gnt, 2'b01);
    check("r31_s", s, 1'b0);
    step(2'b01, 1'b1);
    check("r31_y", y, 8'hA5);
    check("r31_valid", valid, 1'b1);
    step(2'b00, 1'b0);
    i1 = 8'h3C;
    step(2'b11, 1'b1);
    check("r32_first", gnt, 2'b01);
    step(2'b10, 1'b1);
    check("r32_switch_gnt", gnt, 2'b10);
    check("r32_switch_s", s, 1'b1);
    step(2'b10, 1'b1);
    check("r32_y", y, 8'h3C);
    check("r32_valid", valid, 1'b1);
    step(2'b00, 1'b0);
    step(2'b11, 1'b1);
    check("r33_tie1", gnt, 2'b01);
    step(2'b00, 1'b1);
    check("r33_gap1", gnt, 2'b00);
    step(2'b11, 1'b1);
    check("r33_tie2", gnt, 2'b10);
    step(2'b00, 1'b1);
    step(2'b11, 1'b1);
    check("r33_tie3", gnt, 2'b01);
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    check("r34_pre_gnt", gnt, 2'b10);
    check("r34_pre_valid", valid, 1'b1);
    step(2'b11, 1'b0);
    check("r34_rst_gnt", gnt, 2'b00);
    check("r34_rst_s", s, 1'b0);
    check("r34_rst_y", y, 8'h00);
    check("r34_rst_valid", valid, 1'b0);
    step(2'b11, 1'b1);
    check("r34_restart", gnt, 2'b01);
    step(2'b00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(2'b11, 1'b1);
      check("r35_hold", gnt, (TIMEOUT && ((k / MH) % 2 == 1)) ? 2'b10 : 2'b01);
    end
    step(2'b00, 1'b0);
    void'($urandom(32'd20240611));
    for (int k = 0; k < 200; k++) begin
      i0 = W'($urandom);
      i1 = W'($urandom);
      step(2'($urandom), 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
